// File: rtl/func_resp_checker_if.sv
// rtl/func_resp_checker_if.sv - vector sample bus between stimulus/DUT side and response checker
//
// Signals:
//   vec_valid  vec and func_in are valid this cycle
//   vec[3:0]   applied input vector {a,b,c,d}, a is the MSB
//   func_in    function output produced for vec
// Modports:
//   master     drives the sample (stimulus source + function under test)
//   slave      consumes the sample (func_resp_checker)

interface func_resp_checker_if;
    logic       vec_valid;
    logic [3:0] vec;
    logic       func_in;

    modport master (output vec_valid, output vec, output func_in);
    modport slave  (input  vec_valid, input  vec, input  func_in);
endinterface

// File: rtl/func_resp_checker.sv
// rtl/func_resp_checker.sv - truth-table response checker for 4-input function blocks
//
// Compares sampled function outputs against truth table TT, counts matches and
// mismatches, records the first failing vector and reports a verdict after
// NUM_VEC samples.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           one-cycle pulse arming a run (ignored while busy)
//   vec_if          slave side of the sample bus (vec_valid/vec/func_in)
//   busy, done      run in progress / run complete
//   pass            verdict, valid while done is high
//   pass_cnt        matching samples (saturating, CNT_W bits)
//   fail_cnt        mismatching samples (saturating, CNT_W bits)
//   first_fail_vld  a mismatch has been recorded this run
//   first_fail_vec  vector of the first mismatch
//   seen_mask       bit i set once vector i was sampled this run
//
// Optional feature macro: CHK_COVERAGE_EN
//   defined   : seen_mask tracks sampled vectors and pass also requires every
//               vector in COV_MASK to have been seen
//   undefined : seen_mask is tied to 0 and pass depends only on fail_cnt

module func_resp_checker #(
    parameter logic [15:0] TT       = 16'h5555,
    parameter int          NUM_VEC  = 14,
    parameter int          CNT_W    = 8,
    parameter logic [15:0] COV_MASK = 16'h9FFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    func_resp_checker_if.slave   vec_if,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic                 first_fail_vld,
    output logic [3:0]           first_fail_vec,
    output logic [15:0]          seen_mask
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [7:0]       NUM_VEC_C = 8'(NUM_VEC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             ffv_q, ffv_d;
    logic [3:0]       ffvec_q, ffvec_d;
    logic [7:0]       smp_cnt_q, smp_cnt_d;
    logic [15:0]      seen_q, seen_d;
    logic             match;
    logic             cov_ok;

    assign match = (vec_if.func_in == TT[vec_if.vec]);

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        ffv_d      = ffv_q;
        ffvec_d    = ffvec_q;
        smp_cnt_d  = smp_cnt_q;
        seen_d     = seen_q;
        cov_ok     = 1'b1;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A sample arriving together with start is not counted:
                // sampling begins once the FSM is actually in RUN.
                if (start) begin
                    state_d    = S_RUN;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    ffv_d      = 1'b0;
                    ffvec_d    = 4'd0;
                    smp_cnt_d  = 8'd0;
                    seen_d     = 16'd0;
                end
            end
            S_RUN: begin
                if (vec_if.vec_valid) begin
                    if (match) begin
                        if (pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
                    end else begin
                        if (fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
                        if (!ffv_q) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_if.vec;
                        end
                    end
`ifdef CHK_COVERAGE_EN
                    seen_d = seen_q | (16'd1 << vec_if.vec);
                    cov_ok = ((seen_d & COV_MASK) == COV_MASK);
`endif
                    smp_cnt_d = smp_cnt_q + 8'd1;
                    // The final sample is counted above; the verdict uses
                    // the post-update counters so it lands on the same edge.
                    if (smp_cnt_d == NUM_VEC_C) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fail_cnt_d == '0) && cov_ok;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            ffv_q      <= 1'b0;
            ffvec_q    <= 4'd0;
            smp_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            ffv_q      <= ffv_d;
            ffvec_q    <= ffvec_d;
            smp_cnt_q  <= smp_cnt_d;
        end
    end

`ifdef CHK_COVERAGE_EN
    always_ff @(posedge clk) begin
        if (rst) seen_q <= 16'd0;
        else     seen_q <= seen_d;
    end
    assign seen_mask = seen_q;
`else
    // No coverage tracking: the mask stays constant zero.
    assign seen_q    = 16'd0;
    assign seen_mask = 16'd0;
    // COV_MASK has no effect without coverage tracking.
    if (COV_MASK != 16'd0) begin : g_cov_mask_ignored
    end
`endif

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_vec = ffvec_q;

endmodule

// File: tb/tb_func_resp_checker.sv
// tb/tb_func_resp_checker.sv - self-checking bench for func_resp_checker

module tb_func_resp_checker;

    localparam logic [15:0] TT_TB  = 16'h5555;
    localparam int          NV     = 14;
    localparam int          CW     = 8;
    localparam logic [15:0] COV_TB = 16'h9FFF;
    localparam int          CMAX   = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst, start, start_s;

    func_resp_checker_if vif ();
    func_resp_checker_if sif ();

    logic        busy, done, pass, ffv;
    logic [7:0]  pass_cnt, fail_cnt;
    logic [3:0]  ffvec;
    logic [15:0] seen;

    logic        s_busy, s_done, s_pass, s_ffv;
    logic [1:0]  s_pass_cnt, s_fail_cnt;
    logic [3:0]  s_ffvec;
    logic [15:0] s_seen;

    func_resp_checker #(.TT(TT_TB), .NUM_VEC(NV), .CNT_W(CW), .COV_MASK(COV_TB)) u_dut (
        .clk(clk), .rst(rst), .start(start), .vec_if(vif.slave),
        .busy(busy), .done(done), .pass(pass),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_vld(ffv), .first_fail_vec(ffvec), .seen_mask(seen)
    );

    func_resp_checker #(.TT(TT_TB), .NUM_VEC(6), .CNT_W(2), .COV_MASK(COV_TB)) u_sat (
        .clk(clk), .rst(rst), .start(start_s), .vec_if(sif.slave),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt),
        .first_fail_vld(s_ffv), .first_fail_vec(s_ffvec), .seen_mask(s_seen)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a run is a list of samples taken while armed.
    bit          m_armed, m_fin, m_ffv;
    int          m_pass, m_fail, m_ffvec, m_n;
    logic [15:0] m_seen;

    function automatic bit tt_bit(int v);
        return bit'((TT_TB >> v) & 16'h1);
    endfunction

    function automatic void model_step(bit r, bit st, bit vv, int v, bit f);
        if (r) begin
            m_armed = 0; m_fin = 0; m_ffv = 0;
            m_pass = 0; m_fail = 0; m_ffvec = 0; m_n = 0; m_seen = 16'h0;
        end else if (!m_armed && st) begin
            m_armed = 1; m_fin = 0; m_ffv = 0;
            m_pass = 0; m_fail = 0; m_ffvec = 0; m_n = 0; m_seen = 16'h0;
        end else if (m_armed && vv) begin
            if (f == tt_bit(v)) m_pass = (m_pass < CMAX) ? m_pass + 1 : CMAX;
            else begin
                m_fail = (m_fail < CMAX) ? m_fail + 1 : CMAX;
                if (!m_ffv) begin m_ffv = 1; m_ffvec = v; end
            end
            m_seen[v] = 1'b1;
            m_n++;
            if (m_n == NV) begin m_armed = 0; m_fin = 1; end
        end
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        bit          exp_pass;
        logic [15:0] exp_seen;
`ifdef CHK_COVERAGE_EN
        exp_seen = m_seen;
        exp_pass = m_fin && (m_fail == 0) && ((m_seen & COV_TB) == COV_TB);
`else
        exp_seen = 16'h0;
        exp_pass = m_fin && (m_fail == 0);
`endif
        check({tag, "_busy"}, busy, m_armed);
        check({tag, "_done"}, done, m_fin);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_pass_cnt"}, pass_cnt, m_pass);
        check({tag, "_fail_cnt"}, fail_cnt, m_fail);
        check({tag, "_ffv"}, ffv, m_ffv);
        check({tag, "_ffvec"}, ffvec, m_ffvec);
        check({tag, "_seen"}, seen, exp_seen);
    endtask

    task automatic cycle(bit st, bit vv, int v, bit f);
        start         = st;
        vif.vec_valid = vv;
        vif.vec       = v[3:0];
        vif.func_in   = f;
        @(posedge clk);
        model_step(rst, st, vv, v, f);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        rst = 1'b0;
    endtask

    int gold[14] = '{0, 2, 1, 3, 4, 5, 6, 7, 8, 10, 9, 11, 12, 15};

    // Runs the golden order; flip_vec marks vectors whose output is inverted.
    task automatic run_seq(int seq[14], logic [15:0] flip_vec);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 14; i++)
            cycle(0, 1, seq[i], tt_bit(seq[i]) ^ flip_vec[seq[i]]);
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        int cov_seq[14];
        int cnt;
        int budget;
        bit vv, st, f;
        int v;

        rst = 1'b0; start = 1'b0; start_s = 1'b0;
        vif.vec_valid = 1'b0; vif.vec = 4'd0; vif.func_in = 1'b0;
        sif.vec_valid = 1'b0; sif.vec = 4'd0; sif.func_in = 1'b0;
        model_step(1, 0, 0, 0, 0);

        // Reset state
        do_reset();
        check_all("reset");

        // Golden run
        run_seq(gold, 16'h0);
        check_all("gold");
        check("gold_done", done, 1);
        check("gold_pass", pass, 1);
        check("gold_pass_cnt", pass_cnt, 14);
        check("gold_fail_cnt", fail_cnt, 0);
        check("gold_ffv", ffv, 0);
`ifdef CHK_COVERAGE_EN
        check("gold_seen", seen, 16'h9FFF);
`endif

        // Injected faults on vectors 5 and 10 (restart from DONE)
        run_seq(gold, 16'h0420);
        check_all("fault");
        check("fault_fail_cnt", fail_cnt, 2);
        check("fault_pass_cnt", pass_cnt, 12);
        check("fault_ffvec", ffvec, 5);
        check("fault_pass", pass, 0);

        // Coverage miss: vector 15 replaced by a second vector 0
        cov_seq = gold;
        cov_seq[13] = 0;
        run_seq(cov_seq, 16'h0);
        check_all("covmiss");
        check("covmiss_fail_cnt", fail_cnt, 0);
`ifdef CHK_COVERAGE_EN
        check("covmiss_seen", seen, 16'h1FFF);
        check("covmiss_pass", pass, 0);
`else
        check("covmiss_pass", pass, 1);
`endif

        // Gaps and ignored inputs
        do_reset();
        cycle(0, 1, 3, 1);                 // valid in IDLE
        check_all("idle_valid");
        check("idle_valid_cnt", pass_cnt, 0);
        cycle(1, 1, 1, 0);                 // start + valid in IDLE: not counted
        check_all("start_valid");
        check("start_valid_busy", busy, 1);
        check("start_valid_cnt", pass_cnt + fail_cnt, 0);
        for (int i = 0; i < 14; i++) begin
            cycle(0, 0, 0, 0);
            check_all("gap_idle");
            cycle(i == 5, 1, gold[i], tt_bit(gold[i]));   // start mid-run at sample 6
            check_all("gap_smp");
            if (i == 12) check("gap_done_early", done, 0);
        end
        check("gap_done", done, 1);
        check("gap_pass_cnt", pass_cnt, 14);
        cycle(0, 1, 4, 0);                 // valid in DONE
        check_all("done_valid");
        check("done_valid_cnt", fail_cnt, 0);

        // Reset mid-run
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, gold[i], tt_bit(gold[i]) ^ (i == 2));
        rst = 1'b1;
        cycle(1, 1, 7, 1);                 // reset wins over start/valid
        rst = 1'b0;
        check_all("midrst");
        check("midrst_busy", busy, 0);
        check("midrst_pass_cnt", pass_cnt, 0);
        check("midrst_fail_cnt", fail_cnt, 0);
        check("midrst_ffv", ffv, 0);
        check("midrst_ffvec", ffvec, 0);
        run_seq(gold, 16'h0);
        check_all("after_rst");
        check("after_rst_pass", pass, 1);

        // Randomized runs against the model
        for (int r = 0; r < 6; r++) begin
            cycle(1, 0, 0, 0);
            check_all("rnd_start");
            budget = 0;
            while (!m_fin && budget < 300) begin
                vv = ($urandom_range(0, 3) != 0);
                st = ($urandom_range(0, 15) == 0);
                v  = $urandom_range(0, 15);
                f  = tt_bit(v) ^ ($urandom_range(0, 5) == 0);
                cycle(st, vv, v, f);
                check_all("rnd");
                budget++;
            end
            check("rnd_done_in_budget", done, 1);
        end

        // Saturation: CNT_W = 2, NUM_VEC = 6, all samples mismatch
        cycle(0, 0, 0, 0);
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        check("sat_busy", s_busy, 1);
        for (int k = 1; k <= 6; k++) begin
            sif.vec_valid = 1'b1;
            sif.vec       = 4'(k);
            sif.func_in   = ~tt_bit(k);
            @(posedge clk); #1;
            cnt = (k < 3) ? k : 3;
            check("sat_fail_cnt", s_fail_cnt, cnt);
            check("sat_done", s_done, (k == 6));
        end
        sif.vec_valid = 1'b0;
        check("sat_pass", s_pass, 0);
        check("sat_pass_cnt", s_pass_cnt, 0);
        check("sat_ffvec", s_ffvec, 1);
        @(posedge clk); #1;
        check("sat_hold", s_fail_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
